// File: rtl/tremolo_pkg.sv
// rtl/tremolo_pkg.sv - shared FSM state type and width/MAX constants for the tremolo LFO
package tremolo_pkg;

  localparam int DWIDTH_DEF  = 16;
  localparam int AWIDTH_DEF  = 9;
  localparam int PHASE_W_DEF = 24;

  localparam logic [DWIDTH_DEF-1:0] MAX_DEF = {DWIDTH_DEF{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_CALC,
    ST_OUT
  } state_t;

endpackage

// File: rtl/tremolo_depth_scale.sv
// rtl/tremolo_depth_scale.sv - registered gain = MAX - ((depth * (MAX - lfo)) >> DWIDTH)
module tremolo_depth_scale
  import tremolo_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic              en_i,
  input  logic [DWIDTH-1:0] depth_i,
  input  logic [DWIDTH-1:0] lfo_i,
  output logic [DWIDTH-1:0] gain_o
);

  localparam logic [DWIDTH-1:0] MAX = {DWIDTH{1'b1}};

  logic [DWIDTH-1:0]   span;
  logic [2*DWIDTH-1:0] depth_ext;
  logic [2*DWIDTH-1:0] span_ext;
  logic [DWIDTH-1:0]   prod_hi;
  logic [DWIDTH-1:0]   prod_lo_unused;
  logic [DWIDTH-1:0]   gain_d;
  logic [DWIDTH-1:0]   gain_q;

  // Only the upper half of the product survives the >> DWIDTH
  assign span      = MAX - lfo_i;
  assign depth_ext = {{DWIDTH{1'b0}}, depth_i};
  assign span_ext  = {{DWIDTH{1'b0}}, span};
  assign {prod_hi, prod_lo_unused} = depth_ext * span_ext;
  assign gain_d    = MAX - prod_hi;

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      gain_q <= MAX;
    end else if (en_i) begin
      gain_q <= gain_d;
    end
  end

  assign gain_o = gain_q;

endmodule

// File: rtl/tremolo_lfo.sv
// rtl/tremolo_lfo.sv - tremolo LFO gain generator; TREMOLO_QUARTER_WAVE_EN selects quarter-sine ROM mode
module tremolo_lfo
  import tremolo_pkg::*;
#(
  parameter int DWIDTH  = DWIDTH_DEF,
  parameter int AWIDTH  = AWIDTH_DEF,
  parameter int PHASE_W = PHASE_W_DEF
) (
  input  logic               clk_i,
  input  logic               srst_n_i,
  input  logic               sample_valid_i,
  input  logic [PHASE_W-1:0] rate_i,
  input  logic [DWIDTH-1:0]  depth_i,
  output logic [AWIDTH-1:0]  rom_rdaddr_o,
  input  logic [DWIDTH-1:0]  rom_rddata_i,
  output logic [DWIDTH-1:0]  gain_o,
  output logic               gain_valid_o,
  output logic               missed_o
);

  localparam logic [DWIDTH-1:0] MAX = {DWIDTH{1'b1}};

  state_t             state_q;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;
  logic [AWIDTH-1:0]  addr_q;
  logic [AWIDTH-1:0]  addr_d;
  logic [DWIDTH-1:0]  lfo_q;
  logic [DWIDTH-1:0]  lfo_d;
  logic [DWIDTH-1:0]  gain_q;
  logic [DWIDTH-1:0]  scaled_gain;
  logic               gain_valid_q;
  logic               missed_q;

  assign phase_d = phase_q + rate_i;

`ifdef TREMOLO_QUARTER_WAVE_EN
  logic [1:0]        quad;
  logic [AWIDTH-1:0] idx;

  // Odd quadrants walk the quarter table backwards; upper half-cycle mirrors below mid-scale
  assign quad   = phase_q[PHASE_W-1 -: 2];
  assign idx    = phase_q[PHASE_W-3 -: AWIDTH];
  assign addr_d = quad[0] ? ~idx : idx;
  assign lfo_d  = quad[1] ? ((MAX >> 1) - (rom_rddata_i >> 1))
                          : ((MAX >> 1) + (rom_rddata_i >> 1));
`else
  assign addr_d = phase_q[PHASE_W-1 -: AWIDTH];
  assign lfo_d  = rom_rddata_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      addr_q       <= '0;
      lfo_q        <= '0;
      gain_q       <= MAX;
      gain_valid_q <= 1'b0;
      missed_q     <= 1'b0;
    end else begin
      gain_valid_q <= 1'b0;
      if (sample_valid_i && (state_q != ST_IDLE)) begin
        missed_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (sample_valid_i) begin
            phase_q <= phase_d;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          addr_q  <= addr_d;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          lfo_q   <= lfo_d;
          state_q <= ST_CALC;
        end
        ST_CALC: begin
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          gain_q       <= scaled_gain;
          gain_valid_q <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // depth_i is taken live on the CALC edge, so late depth changes still land on this sample
  tremolo_depth_scale #(
    .DWIDTH (DWIDTH)
  ) u_depth_scale (
    .clk_i    (clk_i),
    .srst_n_i (srst_n_i),
    .en_i     (state_q == ST_CALC),
    .depth_i  (depth_i),
    .lfo_i    (lfo_q),
    .gain_o   (scaled_gain)
  );

  assign rom_rdaddr_o = addr_q;
  assign gain_o       = gain_q;
  assign gain_valid_o = gain_valid_q;
  assign missed_o     = missed_q;

endmodule

// File: tb/tb_tremolo_lfo.sv
// tb/tb_tremolo_lfo.sv - self-checking bench for tremolo_lfo against an arithmetic reference model
module tb_tremolo_lfo;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          srst_n;
  logic          sample_valid;
  logic [PW-1:0] rate;
  logic [DW-1:0] depth;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] gain;
  logic          gain_valid;
  logic          missed;

  logic [DW-1:0] rom_mem [512];
  logic          force_en;
  logic [DW-1:0] force_val;

  int     n_checks;
  int     n_fail;
  longint m_phase;

  always #5 clk = ~clk;

  assign rom_data = force_en ? force_val : rom_mem[rom_addr];

  tremolo_lfo #(
    .DWIDTH  (DW),
    .AWIDTH  (AW),
    .PHASE_W (PW)
  ) dut (
    .clk_i          (clk),
    .srst_n_i       (srst_n),
    .sample_valid_i (sample_valid),
    .rate_i         (rate),
    .depth_i        (depth),
    .rom_rdaddr_o   (rom_addr),
    .rom_rddata_i   (rom_data),
    .gain_o         (gain),
    .gain_valid_o   (gain_valid),
    .missed_o       (missed)
  );

  function automatic longint model_addr(input longint ph);
`ifdef TREMOLO_QUARTER_WAVE_EN
    longint q;
    longint idx;
    q   = ph / (longint'(1) << 22);
    idx = (ph / (longint'(1) << 13)) % 512;
    return (q % 2 == 1) ? (511 - idx) : idx;
`else
    return ph / (longint'(1) << 15);
`endif
  endfunction

  function automatic longint model_gain(input longint ph, input longint romv, input longint dep);
    longint lfo;
`ifdef TREMOLO_QUARTER_WAVE_EN
    if (ph / (longint'(1) << 22) >= 2) lfo = 32767 - romv / 2;
    else                                lfo = 32767 + romv / 2;
`else
    lfo = romv;
`endif
    return 65535 - (dep * (65535 - lfo)) / 65536;
  endfunction

  task automatic do_reset();
    srst_n       = 1'b0;
    sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 srst_n = 1'b1;
    m_phase = 0;
  endtask

  task automatic strobe_check(input longint r, input longint dep, input bit mid,
                              input longint dep2, input string name);
    longint exp_addr;
    longint romv;
    longint exp_gain;
    int     pulses;
    int     pulse_cyc;
    m_phase  = (m_phase + r) % (longint'(1) << PW);
    exp_addr = model_addr(m_phase);
    romv     = force_en ? longint'(force_val) : longint'(rom_mem[exp_addr]);
    exp_gain = model_gain(m_phase, romv, mid ? dep2 : dep);
    sample_valid = 1'b1;
    rate         = PW'(r);
    depth        = DW'(dep);
    @(posedge clk);
    #1 sample_valid = 1'b0;
    pulses    = 0;
    pulse_cyc = -1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) begin
        n_checks++;
        if (longint'(rom_addr) !== exp_addr) begin
          n_fail++;
          $display("FAIL %s addr: got %0h expected %0h", name, rom_addr, exp_addr);
        end
        if (mid) depth = DW'(dep2);
      end
      if (gain_valid === 1'b1) begin
        pulses++;
        pulse_cyc = cyc;
        n_checks++;
        if (longint'(gain) !== exp_gain) begin
          n_fail++;
          $display("FAIL %s gain: got %0h expected %0h", name, gain, exp_gain);
        end
      end
    end
    n_checks++;
    if (pulses !== 1 || pulse_cyc !== 4) begin
      n_fail++;
      $display("FAIL %s latency: got %0d pulses at cycle %0d expected 1 at cycle 4", name, pulses, pulse_cyc);
    end
    n_checks++;
    if (longint'(gain) !== exp_gain) begin
      n_fail++;
      $display("FAIL %s hold: got %0h expected %0h", name, gain, exp_gain);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (gain !== 16'hFFFF || gain_valid !== 1'b0 || rom_addr !== 9'h000 || missed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got gain=%0h valid=%0b addr=%0h missed=%0b expected ffff/0/0/0",
               gain, gain_valid, rom_addr, missed);
    end
  endtask

  task automatic test_full_wave_rate();
    for (int i = 0; i < 3; i++) begin
      strobe_check(longint'('h008000), longint'($urandom_range(0, 65535)), 1'b0, 0, "rate_step");
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_depth_bounds();
    force_en  = 1'b1;
    force_val = DW'($urandom);
    strobe_check(longint'($urandom_range(0, 'hFFFFFF)), 0, 1'b0, 0, "depth_zero");
    n_checks++;
    if (gain !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL depth_zero const: got %0h expected ffff", gain);
    end
    force_val = '0;
    strobe_check(longint'($urandom_range(0, 'hFFFFFF)), 'hFFFF, 1'b0, 0, "depth_full");
`ifndef TREMOLO_QUARTER_WAVE_EN
    n_checks++;
    if (gain !== 16'h0001) begin
      n_fail++;
      $display("FAIL depth_full const: got %0h expected 0001", gain);
    end
`endif
    force_en = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    strobe_check(longint'('hFF8000), 'h8000, 1'b0, 0, "wrap_top");
    strobe_check(longint'('h008000), 'h8000, 1'b0, 0, "wrap_zero");
    n_checks++;
    if (rom_addr !== 9'h000) begin
      n_fail++;
      $display("FAIL wrap_zero const: got %0h expected 000", rom_addr);
    end
  endtask

  task automatic test_rate_zero();
    for (int i = 0; i < 2; i++) begin
      strobe_check(0, longint'($urandom_range(0, 65535)), 1'b0, 0, "rate_zero");
    end
  endtask

  task automatic test_depth_midop();
    strobe_check(longint'($urandom_range(0, 'hFFFFFF)), 'h1234, 1'b1, 'hF00D, "depth_midop");
  endtask

  task automatic test_missed();
    int pulses;
    do_reset();
    m_phase = (m_phase + 'h123456) % (longint'(1) << PW);
    sample_valid = 1'b1;
    rate         = 24'h123456;
    depth        = 16'h8000;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    pulses = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) begin
        sample_valid = 1'b1;
        rate         = 24'h7FFFFF;
      end
      if (cyc == 2) sample_valid = 1'b0;
      if (gain_valid === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL missed pulses: got %0d expected 1", pulses);
    end
    n_checks++;
    if (missed !== 1'b1) begin
      n_fail++;
      $display("FAIL missed set: got %0b expected 1", missed);
    end
    strobe_check(longint'('h000100), 'h4000, 1'b0, 0, "after_drop");
    n_checks++;
    if (missed !== 1'b1) begin
      n_fail++;
      $display("FAIL missed sticky: got %0b expected 1", missed);
    end
    do_reset();
    n_checks++;
    if (missed !== 1'b0) begin
      n_fail++;
      $display("FAIL missed clear: got %0b expected 0", missed);
    end
  endtask

  task automatic test_reset_midop();
    int pulses;
    sample_valid = 1'b1;
    rate         = 24'h55AA55;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    pulses = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 2) srst_n = 1'b0;
      if (cyc == 3) srst_n = 1'b1;
      if (gain_valid === 1'b1) pulses++;
    end
    m_phase = 0;
    n_checks++;
    if (pulses !== 0 || gain !== 16'hFFFF || rom_addr !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_midop: got pulses=%0d gain=%0h addr=%0h expected 0/ffff/000",
               pulses, gain, rom_addr);
    end
    strobe_check(longint'('h008000), 'hFFFF, 1'b0, 0, "post_abort");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      strobe_check(longint'($urandom_range(0, 'hFFFFFF)), longint'($urandom_range(0, 65535)),
                   1'b0, 0, "random");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    n_checks++;
    if (missed !== 1'b0) begin
      n_fail++;
      $display("FAIL random missed: got %0b expected 0", missed);
    end
  endtask

`ifdef TREMOLO_QUARTER_WAVE_EN
  task automatic test_quarter();
    do_reset();
    strobe_check(longint'((1 << 22) | (5 << 13)), 'h8000, 1'b0, 0, "quarter_q1");
    n_checks++;
    if (rom_addr !== 9'h1FA) begin
      n_fail++;
      $display("FAIL quarter_q1 const: got %0h expected 1fa", rom_addr);
    end
    force_en  = 1'b1;
    force_val = 16'hFFFF;
    strobe_check(longint'(1 << 22), 'hFFFF, 1'b0, 0, "quarter_q2");
    n_checks++;
    if (gain !== 16'h0001) begin
      n_fail++;
      $display("FAIL quarter_q2 const: got %0h expected 0001", gain);
    end
    force_en = 1'b0;
  endtask
`endif

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    m_phase      = 0;
    force_en     = 1'b0;
    force_val    = '0;
    srst_n       = 1'b0;
    sample_valid = 1'b0;
    rate         = '0;
    depth        = '0;
    for (int i = 0; i < 512; i++) rom_mem[i] = DW'($urandom);

    test_reset();
    test_full_wave_rate();
    test_depth_bounds();
    test_wrap();
    test_rate_zero();
    test_depth_midop();
    test_missed();
    test_reset_midop();
    test_random();
`ifdef TREMOLO_QUARTER_WAVE_EN
    test_quarter();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tremolo_lfo.md
TREMOLO_LFO -- requirements
Module: tremolo_lfo

Interface
REQ-001 Parameter DWIDTH, default 16, SHALL set the ROM data, depth and gain width.
REQ-002 Parameter AWIDTH, default 9, SHALL set the ROM address width.
REQ-003 Parameter PHASE_W, default 24, SHALL set the phase accumulator width, with PHASE_W >= AWIDTH+2.
REQ-004 clk_i  input  1  SHALL be the single clock; all logic SHALL be synchronous to it on the rising edge.
REQ-005 srst_n_i  input  1  SHALL be the synchronous, active-low reset.
REQ-006 sample_valid_i  input  1  SHALL be the one-cycle audio sample-rate strobe.
REQ-007 rate_i  input  PHASE_W  SHALL be the unsigned phase increment per sample.
REQ-008 depth_i  input  DWIDTH  SHALL be the unsigned modulation depth (0 = none, all-ones = full).
REQ-009 rom_rdaddr_o  output  AWIDTH  SHALL be the registered ROM read address.
REQ-010 rom_rddata_i  input  DWIDTH  SHALL be the ROM word, valid one cycle after its address is presented.
REQ-011 gain_o  output  DWIDTH  SHALL be the unsigned gain word for the downstream multiplier.
REQ-012 gain_valid_o  output  1  SHALL pulse for one cycle when gain_o updates.
REQ-013 missed_o  output  1  SHALL be a sticky flag set when a strobe is dropped.

Function
REQ-014 FSM SHALL have states IDLE, READ, WAIT, CALC and OUT, advancing one state per cycle from READ to OUT and then returning to IDLE.
REQ-015 In IDLE, sample_valid_i=1 SHALL update phase <= phase + rate_i (mod 2^PHASE_W) and SHALL move the FSM to READ.
REQ-016 READ SHALL register rom_rdaddr_o from the updated phase.
REQ-017 WAIT SHALL capture rom_rddata_i and form the LFO value lfo.
REQ-018 CALC SHALL register gain = MAX - ((depth_i * (MAX - lfo)) >> DWIDTH), where MAX = 2^DWIDTH-1, using a 2*DWIDTH-bit product and no saturation.
REQ-019 OUT SHALL drive gain_o with the new value and SHALL assert gain_valid_o; latency is 4 cycles from the strobe to gain_valid_o.
REQ-020 gain_o SHALL hold its value between updates.
REQ-021 A sample_valid_i in any state other than IDLE SHALL be ignored, leave phase unchanged and set missed_o.
REQ-022 Phase wrap-around SHALL be silent and modular, with no flag.
REQ-023 rate_i=0 SHALL keep the address constant while still issuing a gain per strobe.
REQ-024 depth_i SHALL be sampled in CALC; a change mid-operation SHALL take effect on that sample.

Reset
REQ-025 While srst_n_i=0, the FSM SHALL go to IDLE, phase to 0, rom_rdaddr_o to 0, gain_o to MAX, gain_valid_o to 0 and missed_o to 0.
REQ-026 A reset asserted mid-operation SHALL abort the operation with no gain_valid_o pulse.
REQ-027 Only reset SHALL clear missed_o.

Configuration
REQ-028 Macro TREMOLO_QUARTER_WAVE_EN defined: the ROM SHALL hold a quarter sine from 0 to MAX, with quadrant q = phase[PHASE_W-1:PHASE_W-2] and idx = phase[PHASE_W-3 -: AWIDTH].
REQ-029 With the macro defined: addr = q[0] ? ~idx : idx, and lfo = q[1] ? (MAX>>1) - (rom>>1) : (MAX>>1) + (rom>>1).
REQ-030 Macro undefined: the ROM SHALL hold a full unipolar wave, with addr = phase[PHASE_W-1 -: AWIDTH] and lfo = rom.

Structure
REQ-031 Package tremolo_pkg SHALL hold the FSM state enum typedef and the MAX/width helper constants.
REQ-032 The ROM SHALL stay outside the block and be instantiated by the parent.
REQ-033 One sub-module, tremolo_depth_scale, SHALL implement the registered CALC multiply and subtract.

Verification
REQ-034 Reset release with no strobes -> gain_o=0xFFFF, gain_valid_o=0, rom_rdaddr_o=0.
REQ-035 Full-wave mode, rate_i=0x008000 and 3 strobes 10 cycles apart -> rom_rdaddr_o = 1, 2, 3, with gain_valid_o exactly 4 cycles after each strobe.
REQ-036 depth_i=0 with any ROM data -> gain_o=0xFFFF; depth_i=0xFFFF with ROM data 0 -> gain_o=0x0001.
REQ-037 Phase preset to 0xFF8000 with rate_i=0x008000 -> rom_rdaddr_o=0x1FF, then 0x000 on the next strobe.
REQ-038 Strobes 2 cycles apart -> the second strobe is dropped, missed_o=1 until reset, and exactly one gain_valid_o pulse occurs.
REQ-039 Quarter-wave mode, q=01 and idx=5 -> rom_rdaddr_o=0x1FA; with q=1x and ROM data 0xFFFF -> lfo=0x0000.
